b01_serial_driver: RTL and testbench

Transmit and receive companion for the b01 serial-flow FSM. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and holds the peer FSM in reset between words. It serializes both operands LSB-first onto `line1`/`line2` and captures the peer's `outp`/`overflw` responses into a parallel result word with a one-cycle `res_valid` pulse. It sits between the concolic test harness (parallel side) and the b01 instance (serial side).

---
 rtl/b01_pkg.sv | 21 ++
 rtl/b01_serial_driver_shifter.sv | 36 +++
 rtl/b01_serial_driver.sv | 125 ++++++++++++
 tb/tb_b01_serial_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/b01_pkg.sv
// Shared types for the b01 serial driver: controller states and the peer's
// state encoding, so monitors can name the b01 `stato` values.
package b01_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } drv_state_e;

    localparam logic [2:0] B01_A   = 3'b000;
    localparam logic [2:0] B01_B   = 3'b001;
    localparam logic [2:0] B01_C   = 3'b010;
    localparam logic [2:0] B01_E   = 3'b011;
    localparam logic [2:0] B01_F   = 3'b100;
    localparam logic [2:0] B01_G   = 3'b101;
    localparam logic [2:0] B01_WF0 = 3'b110;
    localparam logic [2:0] B01_WF1 = 3'b111;

endpackage

// File: rtl/b01_serial_driver_shifter.sv
// Parallel-load, LSB-first serializer. The output bit is a register so the
// serial line changes only on clock edges; it returns to 0 when not shifting.
module serial_shifter
    import b01_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic             bit_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q  <= '0;
            bit_q <= 1'b0;
        end else if (load_i) begin
            sr_q  <= data_i >> 1;
            bit_q <= data_i[0];
        end else if (shift_i) begin
            sr_q  <= sr_q >> 1;
            bit_q <= sr_q[0];
        end else begin
            bit_q <= 1'b0;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/b01_serial_driver.sv
// Drives one operand pair LSB-first into a b01 peer and gathers its outp /
// overflw responses into a parallel result. WIDTH >= 1, CAP_DLY >= 1.
module b01_serial_driver
    import b01_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CAP_DLY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             line1,
    output logic             line2,
    output logic             dut_reset,
    input  logic             outp_in,
    input  logic             overflw_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf
);

    localparam int            CW         = $clog2(WIDTH + CAP_DLY) + 1;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] WORD_LAST  = CW'(WIDTH + CAP_DLY - 1);
    localparam logic [CW-1:0] FIRST_SMP  = CW'(CAP_DLY);

    drv_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] res_data_q;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, dut_reset_q, res_valid_q, res_ovf_q;
    logic             accept, shift_en, sample_en;

    // cnt_q counts cycles since accept; the response to bit k lands at cnt_q = k + CAP_DLY.
    assign accept    = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign shift_en  = (state_q == ST_SHIFT) && (cnt_q < SHIFT_LAST);
    assign sample_en = ((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && (cnt_q >= FIRST_SMP);

    always_comb begin
        cap_d          = cap_q >> 1;
        cap_d[WIDTH-1] = outp_in;
        ovf_d          = ovf_q | overflw_in;
    end

    serial_shifter #(.WIDTH(WIDTH)) u_sh_a (
        .clock   (clock),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (in_a),
        .bit_o   (line1)
    );

    serial_shifter #(.WIDTH(WIDTH)) u_sh_b (
        .clock   (clock),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (in_b),
        .bit_o   (line2)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cap_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            dut_reset_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    in_ready_q  <= 1'b1;
                    dut_reset_q <= 1'b1;
                    if (accept) begin
                        state_q     <= ST_SHIFT;
                        cnt_q       <= '0;
                        cap_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b0;
                        dut_reset_q <= 1'b0;
                    end
                end
                ST_SHIFT, ST_DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sample_en) begin
                        cap_q <= cap_d;
                        ovf_q <= ovf_d;
                    end
                    // The last sample is taken on the same edge that enters DONE.
                    if (cnt_q == WORD_LAST) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        dut_reset_q <= 1'b1;
                        res_data_q  <= cap_d;
                        res_ovf_q   <= ovf_d;
                    end else if (cnt_q == SHIFT_LAST) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign dut_reset = dut_reset_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_b01_serial_driver.sv
// Directed bench: loopback and b01-peer words on a CAP_DLY=1 instance,
// a 3-register loopback on a CAP_DLY=3 instance.
module tb_b01_serial_driver;
    import b01_pkg::*;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic         in_valid1 = 1'b0;
    logic [W-1:0] in_a1 = '0, in_b1 = '0;
    logic         in_ready1, line1_1, line2_1, dut_reset1, outp1, ovf1, res_valid1, res_ovf1;
    logic [W-1:0] res_data1;

    logic         in_valid3 = 1'b0;
    logic [W-1:0] in_a3 = '0, in_b3 = '0;
    logic         in_ready3, line1_3, line2_3, dut_reset3, res_valid3, res_ovf3;
    logic [W-1:0] res_data3;

    logic       peer_sel  = 1'b0;
    logic       ovf_force = 1'b0;
    logic       lb1_q = 1'b0;
    logic [2:0] lb3_q = '0;
    logic [2:0] stato = B01_A;
    logic       b_outp = 1'b0, b_ovf = 1'b0;

    assign outp1 = peer_sel ? b_outp : lb1_q;
    assign ovf1  = ovf_force | (peer_sel & b_ovf);

    always @(posedge clock) begin
        lb1_q <= line1_1;
        lb3_q <= {lb3_q[1:0], line1_3};
    end

    // Behavioural b01 peer, held in reset by the driver.
    always @(posedge clock) begin
        if (dut_reset1) begin
            stato  <= B01_A;
            b_outp <= 1'b0;
            b_ovf  <= 1'b0;
        end else begin
            b_ovf <= 1'b0;
            case (stato)
                B01_A:   begin stato <= (line1_1 & line2_1) ? B01_F : B01_B;     b_outp <= line1_1 ^ line2_1; end
                B01_E:   begin stato <= (line1_1 & line2_1) ? B01_F : B01_B;     b_outp <= line1_1 ^ line2_1; b_ovf <= 1'b1; end
                B01_B:   begin stato <= (line1_1 & line2_1) ? B01_G : B01_C;     b_outp <= line1_1 ^ line2_1; end
                B01_F:   begin stato <= (line1_1 | line2_1) ? B01_G : B01_C;     b_outp <= ~(line1_1 ^ line2_1); end
                B01_C:   begin stato <= (line1_1 & line2_1) ? B01_WF1 : B01_WF0; b_outp <= line1_1 ^ line2_1; end
                B01_G:   begin stato <= (line1_1 | line2_1) ? B01_WF1 : B01_WF0; b_outp <= ~(line1_1 ^ line2_1); end
                B01_WF0: begin stato <= (line1_1 & line2_1) ? B01_E : B01_A;     b_outp <= line1_1 ^ line2_1; end
                default: begin stato <= (line1_1 | line2_1) ? B01_E : B01_A;     b_outp <= ~(line1_1 ^ line2_1); end
            endcase
        end
    end

    b01_serial_driver #(.WIDTH(W), .CAP_DLY(1)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .line1(line1_1), .line2(line2_1), .dut_reset(dut_reset1),
        .outp_in(outp1), .overflw_in(ovf1), .res_valid(res_valid1), .res_data(res_data1),
        .res_ovf(res_ovf1)
    );

    b01_serial_driver #(.WIDTH(W), .CAP_DLY(3)) u_dut3 (
        .clock(clock), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .line1(line1_3), .line2(line2_3), .dut_reset(dut_reset3),
        .outp_in(lb3_q[2]), .overflw_in(1'b0), .res_valid(res_valid3), .res_data(res_data3),
        .res_ovf(res_ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accept1(input logic [W-1:0] a, input logic [W-1:0] b, output int t);
        int n = 0;
        while (!in_ready1 && n < 40) begin tick(); n++; end
        chk("accept_ready", 32'(in_ready1), 32'd1);
        in_a1 = a; in_b1 = b; in_valid1 = 1'b1; t = cyc;
        tick();
        in_valid1 = 1'b0;
    endtask

    task automatic wait_res1(input string tag, input int t, input logic [W-1:0] exp_d, input logic exp_o);
        int n = 0;
        while (!res_valid1 && n < 40) begin tick(); n++; end
        chk($sformatf("%s_lat", tag), cyc - t, 32'd10);
        chk($sformatf("%s_data", tag), 32'(res_data1), 32'(exp_d));
        chk($sformatf("%s_ovf", tag), 32'(res_ovf1), 32'(exp_o));
        tick();
        chk($sformatf("%s_pulse", tag), 32'(res_valid1), 32'd0);
        chk($sformatf("%s_hold", tag), 32'(res_data1), 32'(exp_d));
        chk($sformatf("%s_rdy", tag), 32'(in_ready1), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, n, last, nacc, tacc, rv;
        logic [W-1:0] ea, eb, l2w;

        repeat (3) tick();
        chk("rst_ready", 32'(in_ready1), 32'd0);
        chk("rst_dutrst", 32'(dut_reset1), 32'd1);
        chk("rst_lines", 32'({line1_1, line2_1}), 32'd0);
        chk("rst_valid", 32'(res_valid1), 32'd0);
        chk("rst_data", 32'(res_data1), 32'd0);
        chk("rst_ovf", 32'(res_ovf1), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(in_ready1), 32'd1);
        chk("idle_dutrst", 32'(dut_reset1), 32'd1);

        // loopback, CAP_DLY=1
        accept1(8'hA5, 8'h00, t);
        chk("lb_dutrst_shift", 32'(dut_reset1), 32'd0);
        chk("lb_line1_b0", 32'(line1_1), 32'd1);
        wait_res1("lb", t, 8'hA5, 1'b0);

        // real b01 peer
        peer_sel = 1'b1;
        accept1(8'h00, 8'h00, t);
        chk("st_t1", 32'(stato), 32'(B01_A));  tick();
        chk("st_t2", 32'(stato), 32'(B01_B));  tick();
        chk("st_t3", 32'(stato), 32'(B01_C));  tick();
        chk("st_t4", 32'(stato), 32'(B01_WF0)); tick();
        chk("st_t5", 32'(stato), 32'(B01_A));
        wait_res1("b01z", t, 8'h00, 1'b0);
        accept1(8'hFF, 8'h00, t);
        wait_res1("b01a", t, 8'hFF, 1'b0);
        accept1(8'hFF, 8'hFF, t);
        wait_res1("b01ab", t, 8'hEE, 1'b1);
        peer_sel = 1'b0;

        // overflow forced only in the bit-3 sample cycle, then only while idle
        accept1(8'h5A, 8'h00, t);
        repeat (4) tick();
        ovf_force = 1'b1;
        tick();
        ovf_force = 1'b0;
        wait_res1("ovf_b3", t, 8'h5A, 1'b1);
        ovf_force = 1'b1;
        repeat (2) tick();
        accept1(8'h33, 8'h00, t);
        ovf_force = 1'b0;
        wait_res1("ovf_idle", t, 8'h33, 1'b0);

        // in_valid held high, operands scrambled every cycle
        last = -1; nacc = 0; tacc = -100; ea = '0; eb = '0; l2w = '0;
        in_a1 = 8'hC6; in_b1 = 8'h2D; in_valid1 = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (i == 30) in_valid1 = 1'b0;
            if (res_valid1) begin
                chk("tp_data", 32'(res_data1), 32'(ea));
                chk("tp_line2", 32'(l2w), 32'(eb));
            end
            if (cyc >= tacc + 1 && cyc <= tacc + W) l2w[cyc - tacc - 1] = line2_1;
            if (in_ready1 && in_valid1) begin
                if (last >= 0) chk("tp_period", cyc - last, 32'd11);
                last = cyc; tacc = cyc; ea = in_a1; eb = in_b1; l2w = '0; nacc++;
            end
            tick();
            in_a1 = W'($urandom); in_b1 = W'($urandom);
        end
        chk("tp_count", nacc, 32'd3);

        // reset during SHIFT bit 4
        accept1(8'h81, 8'h00, t);
        wait_res1("pre_rst", t, 8'h81, 1'b0);
        accept1(8'hF0, 8'hF0, t);
        repeat (4) tick();
        chk("rs_bit4", 32'(line1_1), 32'd1);
        reset = 1'b1;
        tick();
        chk("rs_valid", 32'(res_valid1), 32'd0);
        chk("rs_data", 32'(res_data1), 32'd0);
        chk("rs_dutrst", 32'(dut_reset1), 32'd1);
        chk("rs_ready", 32'(in_ready1), 32'd0);
        chk("rs_line1", 32'(line1_1), 32'd0);
        reset = 1'b0;
        tick();
        chk("rs_ready_after", 32'(in_ready1), 32'd1);
        rv = 0;
        for (int i = 0; i < 14; i++) begin
            if (res_valid1) rv++;
            tick();
        end
        chk("rs_no_valid", rv, 32'd0);
        chk("rs_data_after", 32'(res_data1), 32'd0);

        // CAP_DLY=3 with a 3-register loopback
        n = 0;
        while (!in_ready3 && n < 40) begin tick(); n++; end
        in_a3 = 8'h3C; in_b3 = 8'hC3; in_valid3 = 1'b1; t = cyc;
        tick();
        in_valid3 = 1'b0;
        chk("c3_line2_b0", 32'(line2_3), 32'd1);
        chk("c3_dutrst", 32'(dut_reset3), 32'd0);
        n = 0;
        while (!res_valid3 && n < 40) begin tick(); n++; end
        chk("c3_lat", cyc - t, 32'd12);
        chk("c3_data", 32'(res_data3), 32'h3C);
        chk("c3_ovf", 32'(res_ovf3), 32'd0);
        tick();
        chk("c3_ready", 32'(in_ready3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
